// File: rtl/frac_clken_gen.sv
`timescale 1ns/1ps
// frac_clken_gen
// Multi-channel fractional clock-enable generator running on the PLL output
// clock. Each channel adds its increment into a phase accumulator every cycle
// while the PLL has been stably locked; the carry out of that add becomes a
// one-cycle enable, so channel i fires at refclk * inc[i] / 2^ACC_W.
//
// Ports:
//   refclk      PLL output clock, the only clock
//   rst_n       asynchronous active-low reset
//   locked      PLL lock, asynchronous to refclk (synchronised here)
//   wr_valid    increment write request
//   wr_ready    write accepted when wr_valid && wr_ready
//   wr_ch       target channel (out-of-range channels are accepted and dropped)
//   wr_inc      new increment
//   wr_mode     0 = deferred (apply at next wrap), 1 = immediate (apply, clear acc)
//   resync      one-cycle pulse that phase-aligns all channels
//   ce          per-channel enable pulses
//   ce_half     per-channel midpoint pulses (only with FRAC_CLKEN_HALF_EN)
//   active      high while enables are running
//   unlock_cnt  saturating count of lock losses while running
//
// Build option: define FRAC_CLKEN_HALF_EN to add the ce_half output.
//
// FSM states:
//   state     | meaning
//   WAIT_LOCK | waiting for synchronised lock; accumulators held at 0
//   SETTLE    | lock seen, counting LOCK_WAIT cycles of stable lock
//   RUN       | accumulators running, enables live
module frac_clken_gen #(
  parameter int              NUM_CH      = 4,
  parameter int              ACC_W       = 32,
  parameter int              LOCK_WAIT   = 1024,
  parameter longint unsigned INC_DEFAULT = 0,
  localparam int             CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ACC_W-1:0]  wr_inc,
  input  logic              wr_mode,
  input  logic              resync,
  output logic [NUM_CH-1:0] ce,
`ifdef FRAC_CLKEN_HALF_EN
  output logic [NUM_CH-1:0] ce_half,
`endif
  output logic              active,
  output logic [7:0]        unlock_cnt
);

  localparam logic [15:0]      SETTLE_LAST = 16'(LOCK_WAIT - 1);
  localparam logic [ACC_W-1:0] INC_RST     = ACC_W'(INC_DEFAULT);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        lock_meta;
  logic        lock_s;
  logic [15:0] settle_cnt;
  logic        run;

  logic [ACC_W-1:0] acc    [NUM_CH];
  logic [ACC_W-1:0] inc    [NUM_CH];
  logic [ACC_W-1:0] shadow [NUM_CH];
  logic [ACC_W:0]   sum    [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] imm_wr;
  logic [NUM_CH-1:0] def_wr;

  // Lock synchroniser
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
    end
  end

  // FSM: state register
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_LOCK;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!lock_s)                        state_nxt = WAIT_LOCK;
        else if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!lock_s) state_nxt = WAIT_LOCK;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run    = (state == RUN);
    active = run;
  end

  // Settle counter is held clear while waiting so SETTLE always starts at 0
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state == WAIT_LOCK) begin
      settle_cnt <= '0;
    end else if (state == SETTLE) begin
      settle_cnt <= settle_cnt + 16'd1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      unlock_cnt <= '0;
    end else if (run && !lock_s && (unlock_cnt != 8'hFF)) begin
      unlock_cnt <= unlock_cnt + 8'd1;
    end
  end

  // Write decode; a channel number with no match is simply never hit,
  // which both accepts and discards out-of-range writes.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = (wr_ch == i[CH_W-1:0]);
    end
    imm_wr   = {NUM_CH{wr_valid &  wr_mode}} & wr_hit;
    def_wr   = {NUM_CH{wr_valid & ~wr_mode}} & wr_hit & ~pending;
    wr_ready = ~|(wr_hit & pending);
  end

  // One extra bit keeps the carry that becomes the enable
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
    end
  end

  // Channel datapath. Priority per channel: immediate write, then the
  // "clear" cases (not running, or resync), then normal accumulation.
  // A deferred write can only land when nothing is pending, so it never
  // collides with a shadow load on the same channel.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]    <= '0;
        inc[i]    <= INC_RST;
        shadow[i] <= '0;
      end
      pending <= '0;
      ce      <= '0;
`ifdef FRAC_CLKEN_HALF_EN
      ce_half <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (imm_wr[i]) begin
          inc[i]     <= wr_inc;
          acc[i]     <= '0;
          ce[i]      <= 1'b0;
          pending[i] <= 1'b0;
`ifdef FRAC_CLKEN_HALF_EN
          ce_half[i] <= 1'b0;
`endif
        end else if (!run || resync) begin
          acc[i] <= '0;
          ce[i]  <= 1'b0;
`ifdef FRAC_CLKEN_HALF_EN
          ce_half[i] <= 1'b0;
`endif
          if (pending[i]) begin
            inc[i]     <= shadow[i];
            pending[i] <= 1'b0;
          end
        end else begin
          acc[i] <= sum[i][ACC_W-1:0];
          ce[i]  <= sum[i][ACC_W];
`ifdef FRAC_CLKEN_HALF_EN
          // Midpoint: top accumulator bit rises without a wrap
          ce_half[i] <= ~sum[i][ACC_W] & ~acc[i][ACC_W-1] & sum[i][ACC_W-1];
`endif
          if (sum[i][ACC_W] && pending[i]) begin
            inc[i]     <= shadow[i];
            pending[i] <= 1'b0;
          end
        end
        if (def_wr[i]) begin
          shadow[i]  <= wr_inc;
          pending[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frac_clken_gen.sv
`timescale 1ns/1ps
module tb_frac_clken_gen;

  localparam int NUM_CH    = 4;
  localparam int ACC_W     = 8;
  localparam int LOCK_WAIT = 16;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_ch;
  logic [7:0] wr_inc;
  logic       wr_mode;
  logic       resync;
  logic [3:0] ce;
`ifdef FRAC_CLKEN_HALF_EN
  logic [3:0] ce_half;
`endif
  logic       active;
  logic [7:0] unlock_cnt;

  always #5 refclk = ~refclk;

  frac_clken_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .LOCK_WAIT  (LOCK_WAIT),
    .INC_DEFAULT(0)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .locked    (locked),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_ch     (wr_ch),
    .wr_inc    (wr_inc),
    .wr_mode   (wr_mode),
    .resync    (resync),
    .ce        (ce),
`ifdef FRAC_CLKEN_HALF_EN
    .ce_half   (ce_half),
`endif
    .active    (active),
    .unlock_cnt(unlock_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int pulse_cnt [4];

  typedef struct packed {
    logic [3:0] mask;
    logic [3:0] ce;
    logic [3:0] half;
  } exp_t;

  exp_t exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Ideal fractional divider: with the accumulator at 0 before cycle 1,
  // cycle n carries out when floor(n*inc/256) steps.
  function automatic logic pulse_at(input int inc, input int n);
    return ((n * inc) / 256) != (((n - 1) * inc) / 256);
  endfunction

  function automatic logic half_at(input int inc, input int n);
    int a0;
    int a1;
    a0 = ((n - 1) * inc) % 256;
    a1 = (n * inc) % 256;
    return (a0 < 128) && (a1 >= 128) && !pulse_at(inc, n);
  endfunction

  task automatic push_window(input int inc0, input int inc1, input int inc2, input int inc3,
                             input int n_cyc, input logic [3:0] mask);
    int incs [4];
    incs = '{inc0, inc1, inc2, inc3};
    for (int n = 1; n <= n_cyc; n++) begin
      exp_t e;
      e.mask = mask;
      for (int c = 0; c < 4; c++) begin
        e.ce[c]   = pulse_at(incs[c], n);
        e.half[c] = half_at(incs[c], n);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 4; c++) pulse_cnt[c] = 0;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tick();
      chk(tag, 32'(ce & e.mask), 32'(e.ce & e.mask));
`ifdef FRAC_CLKEN_HALF_EN
      chk({tag, "_half"}, 32'(ce_half & e.mask), 32'(e.half & e.mask));
`endif
      for (int c = 0; c < 4; c++) if (ce[c]) pulse_cnt[c]++;
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] inc, input logic mode);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_inc   = inc;
    wr_mode  = mode;
    tick();
    wr_valid = 1'b0;
    wr_mode  = 1'b0;
  endtask

  task automatic wait_active(output int n);
    n = 0;
    while (!active && n < 100) begin
      tick();
      n++;
    end
    chk("active_timeout", 32'(active), 32'd1);
  endtask

  // Latency is counted in edges after the first edge that samples locked=1
  task automatic relock_latency(input string tag);
    int n;
    n = 0;
    tick();
    while (!active && n < 100) begin
      chk({tag, "_ce_quiet"}, 32'(ce), 32'd0);
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd18);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    locked   = 1'b1;
    wr_valid = 1'b0;
    wr_ch    = 2'd0;
    wr_inc   = 8'd0;
    wr_mode  = 1'b0;
    resync   = 1'b0;
    tick();
    tick();
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_unlock", 32'(unlock_cnt), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);

    // Lock-up latency with writes landing while still settling
    rst_n = 1'b1;
    n = 0;
    tick();
    while (!active && n < 100) begin
      chk("ce_before_active", 32'(ce), 32'd0);
      case (n)
        2: begin wr_valid = 1'b1; wr_mode = 1'b1; wr_ch = 2'd0; wr_inc = 8'd64;  end
        3: begin wr_valid = 1'b1; wr_mode = 1'b1; wr_ch = 2'd1; wr_inc = 8'd96;  end
        4: begin wr_valid = 1'b1; wr_mode = 1'b1; wr_ch = 2'd2; wr_inc = 8'd255; end
        default: begin wr_valid = 1'b0; wr_mode = 1'b0; end
      endcase
      tick();
      n++;
    end
    wr_valid = 1'b0;
    wr_mode  = 1'b0;
    chk("lock_latency", n, 32'd18);

    // Steady rates from phase 0
    push_window(64, 96, 255, 0, 256, 4'hF);
    drain("run_rates");
    chk("ce0_count", pulse_cnt[0], 32'd64);
    chk("ce1_count", pulse_cnt[1], 32'd96);
    chk("ce2_count", pulse_cnt[2], 32'd255);
    chk("ce3_count", pulse_cnt[3], 32'd0);

    // Deferred write: acc0 is 0 here, so the wrap is 4 edges away
    wr_valid = 1'b1; wr_mode = 1'b0; wr_ch = 2'd0; wr_inc = 8'd128;
    #1;
    chk("def_ready_idle", 32'(wr_ready), 32'd1);
    tick();
    wr_inc = 8'd200;
    #1;
    chk("def_stall_ch0", 32'(wr_ready), 32'd0);
    tick();
    wr_ch = 2'd3; wr_inc = 8'd16;
    #1;
    chk("def_other_ch", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0; wr_ch = 2'd0;
    #1;
    chk("def_pending_ch0", 32'(wr_ready), 32'd0);
    chk("def_no_wrap_yet", 32'(ce[0]), 32'd0);
    tick();
    chk("def_wrap_ce0", 32'(ce[0]), 32'd1);
    #1;
    chk("def_ready_after_wrap", 32'(wr_ready), 32'd1);
    wr_ch = 2'd3;
    #1;
    chk("def_pending_ch3", 32'(wr_ready), 32'd0);
    wr_ch = 2'd0;
    push_window(128, 0, 0, 0, 8, 4'b0001);
    drain("run_def");

    // Lock loss: ch3's shadow (16) loads while out of RUN
    locked = 1'b0;
    tick();
    tick();
    tick();
    chk("unlock_active", 32'(active), 32'd0);
    chk("unlock_cnt_1", 32'(unlock_cnt), 32'd1);
    locked = 1'b1;
    // The first edge after leaving RUN must show ce cleared
    @(posedge refclk);
    #1;
    chk("unlock_ce", 32'(ce), 32'd0);
    n = 0;
    while (!active && n < 100) begin
      chk("relock_ce_quiet", 32'(ce), 32'd0);
      tick();
      n++;
    end
    chk("relock_latency", n, 32'd18);
    push_window(128, 96, 255, 16, 32, 4'hF);
    drain("relock_phase");
    chk("unlock_cnt_keep", 32'(unlock_cnt), 32'd1);

    // Saturation of the lock-loss counter
    for (int k = 2; k <= 300; k++) begin
      locked = 1'b0;
      repeat (3) tick();
      locked = 1'b1;
      wait_active(n);
      if (k == 254) chk("unlock_254", 32'(unlock_cnt), 32'd254);
    end
    chk("unlock_sat", 32'(unlock_cnt), 32'd255);

    // Resync beats an overflow (ch2 at 255 carries on nearly every edge)
    repeat (5) tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("resync_no_ce", 32'(ce), 32'd0);
    push_window(128, 96, 255, 16, 16, 4'hF);
    drain("post_resync");

    // Resync with a pending shadow and a same-cycle immediate write
    wr(2'd0, 8'd64, 1'b1);
    wr(2'd1, 8'd32, 1'b1);
    wr(2'd3, 8'd64, 1'b0);
    resync = 1'b1;
    wr_valid = 1'b1; wr_mode = 1'b1; wr_ch = 2'd2; wr_inc = 8'd128;
    tick();
    resync = 1'b0; wr_valid = 1'b0; wr_mode = 1'b0;
    chk("resync_imm_no_ce", 32'(ce), 32'd0);
    push_window(64, 32, 128, 64, 32, 4'hF);
    drain("resync_imm");

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ce", 32'(ce), 32'd0);
    chk("arst_active", 32'(active), 32'd0);
    chk("arst_unlock", 32'(unlock_cnt), 32'd0);
    chk("arst_ready", 32'(wr_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
